// File: rtl/pulse_gen.sv
// -----------------------------------------------------------------------------
// pulse_gen
//
// Turns a single-cycle trigger strobe into a fixed-length pulse on a registered
// output pin.  Consecutive pulses are separated by a guaranteed inactive gap.
// Triggers that arrive while a pulse or gap is in progress are either queued
// or discarded.  A discarded trigger is reported with a one-cycle strobe.
//
// Build option:
//   PULSE_GEN_QUEUE_EN  defined   -> 2-bit saturating request queue (max 3 waiting)
//                       undefined -> no queue; a trigger while busy is discarded,
//                                    except in the final gap cycle, where it
//                                    starts the next pulse.
//
// Parameters:
//   HIGH_CYCLES   active pulse length in clk cycles (1..255)
//   GAP_CYCLES    minimum inactive cycles between pulses (0..255)
//   ACTIVE_LEVEL  level driven on out during a pulse; idle level is its inverse
//
// Ports:
//   clk      in   single clock, rising-edge
//   rst      in   asynchronous active-high reset
//   trig     in   single-cycle request strobe, synchronous to clk
//   out      out  registered pulse output
//   busy     out  registered; high while a pulse, gap or queued request exists
//   dropped  out  registered one-cycle strobe, the cycle after a discarded trig
// -----------------------------------------------------------------------------
module pulse_gen #(
   parameter int unsigned HIGH_CYCLES  = 4,
   parameter int unsigned GAP_CYCLES   = 2,
   parameter logic        ACTIVE_LEVEL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic trig,
   output logic out,
   output logic busy,
   output logic dropped
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_GAP    = 2'd2
   } state_t;

   // Counter reload values: the counter runs from N-1 down to 0, so a phase
   // lasts exactly N cycles.
   localparam logic [7:0] HIGH_LOAD  = 8'(HIGH_CYCLES - 1);
   localparam logic [7:0] GAP_LOAD   = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);
   localparam logic       GAP_EN     = (GAP_CYCLES != 0) ? 1'b1 : 1'b0;
   localparam logic       IDLE_LEVEL = ~ACTIVE_LEVEL;

`ifdef PULSE_GEN_QUEUE_EN
   localparam logic QUEUE_EN = 1'b1;
`else
   localparam logic QUEUE_EN = 1'b0;
`endif

   state_t     state_r;
   state_t     state_nxt_s;
   logic [7:0] cnt_r;
   logic [7:0] cnt_nxt_s;
   logic       out_r;
   logic       out_nxt_s;
   logic       busy_r;
   logic       busy_nxt_s;
   logic       dropped_r;
   logic       dropped_nxt_s;
   logic [1:0] pending_s;
   logic [1:0] pending_nxt_s;
   logic       gap_end_s;
   logic       can_queue_s;

`ifdef PULSE_GEN_QUEUE_EN
   logic [1:0] pending_r;

   // Queued-request counter; cleared by reset without any dropped strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_r <= 2'd0;
      end else begin
         pending_r <= pending_nxt_s;
      end
   end

   assign pending_s = pending_r;
`else
   assign pending_s = 2'd0;
`endif

   // A trigger may be queued only when the queue exists and is not full
   assign can_queue_s = QUEUE_EN && (pending_s != 2'd3);

   // Last cycle of the inactive gap.  With no gap configured, the last active
   // cycle takes that role so pulses can run back-to-back.
   always_comb begin
      gap_end_s = 1'b0;
      case (state_r)
         S_ACTIVE: gap_end_s = (cnt_r == 8'd0) && !GAP_EN;
         S_GAP:    gap_end_s = (cnt_r == 8'd0);
         default:  gap_end_s = 1'b0;
      endcase
   end

   // Next-state, counter, queue and drop-strobe decode
   always_comb begin
      state_nxt_s   = state_r;
      cnt_nxt_s     = cnt_r;
      out_nxt_s     = out_r;
      pending_nxt_s = pending_s;
      dropped_nxt_s = 1'b0;

      case (state_r)
         S_IDLE: begin
            if (trig) begin
               state_nxt_s = S_ACTIVE;
               cnt_nxt_s   = HIGH_LOAD;
               out_nxt_s   = ACTIVE_LEVEL;
            end else begin
               cnt_nxt_s   = 8'd0;
               out_nxt_s   = IDLE_LEVEL;
            end
         end

         S_ACTIVE, S_GAP: begin
            if (gap_end_s) begin
               if (pending_s != 2'd0) begin
                  // Oldest queued request starts now; a trig arriving in the
                  // same cycle takes its place in the queue.
                  state_nxt_s = S_ACTIVE;
                  cnt_nxt_s   = HIGH_LOAD;
                  out_nxt_s   = ACTIVE_LEVEL;
                  if (trig) begin
                     pending_nxt_s = pending_s;
                  end else begin
                     pending_nxt_s = pending_s - 2'd1;
                  end
               end else if (trig) begin
                  // Trig in the final gap cycle starts the next pulse directly
                  state_nxt_s = S_ACTIVE;
                  cnt_nxt_s   = HIGH_LOAD;
                  out_nxt_s   = ACTIVE_LEVEL;
               end else begin
                  state_nxt_s = S_IDLE;
                  cnt_nxt_s   = 8'd0;
                  out_nxt_s   = IDLE_LEVEL;
               end
            end else begin
               if (cnt_r != 8'd0) begin
                  cnt_nxt_s = cnt_r - 8'd1;
                  out_nxt_s = (state_r == S_ACTIVE) ? ACTIVE_LEVEL : IDLE_LEVEL;
               end else begin
                  // Only ACTIVE with a non-zero gap gets here
                  state_nxt_s = S_GAP;
                  cnt_nxt_s   = GAP_LOAD;
                  out_nxt_s   = IDLE_LEVEL;
               end

               if (trig) begin
                  if (can_queue_s) begin
                     pending_nxt_s = pending_s + 2'd1;
                  end else begin
                     dropped_nxt_s = 1'b1;
                  end
               end else begin
                  pending_nxt_s = pending_s;
               end
            end
         end

         default: begin
            state_nxt_s   = S_IDLE;
            cnt_nxt_s     = 8'd0;
            out_nxt_s     = IDLE_LEVEL;
            pending_nxt_s = 2'd0;
         end
      endcase

      busy_nxt_s = (state_nxt_s != S_IDLE) || (pending_nxt_s != 2'd0);
   end

   // State, counter and output registers; reset drives the pin idle at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= S_IDLE;
         cnt_r     <= 8'd0;
         out_r     <= IDLE_LEVEL;
         busy_r    <= 1'b0;
         dropped_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         out_r     <= out_nxt_s;
         busy_r    <= busy_nxt_s;
         dropped_r <= dropped_nxt_s;
      end
   end

   assign out     = out_r;
   assign busy    = busy_r;
   assign dropped = dropped_r;

endmodule

// File: tb/tb_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_pulse_gen
//
// Directed self-checking bench for pulse_gen.  dut0 uses the default
// parameters (HIGH=4, GAP=2, ACTIVE_LEVEL=1); dut1 uses HIGH=4, GAP=0,
// ACTIVE_LEVEL=0.  Expectations depending on the request queue follow the
// PULSE_GEN_QUEUE_EN macro.  Cycle k means the k-th cycle after the cycle in
// which the first trig of a sequence is driven (that cycle is cycle 0).
// -----------------------------------------------------------------------------
module tb_pulse_gen;

   logic clk = 1'b0;
   logic rst;
   logic trig0;
   logic trig1;
   logic out0, busy0, dropped0;
   logic out1, busy1, dropped1;

   int n_cmp = 0;
   int n_err = 0;
   int k;

   always #5 clk = ~clk;

   pulse_gen #(
      .HIGH_CYCLES  (4),
      .GAP_CYCLES   (2),
      .ACTIVE_LEVEL (1'b1)
   ) dut0 (
      .clk     (clk),
      .rst     (rst),
      .trig    (trig0),
      .out     (out0),
      .busy    (busy0),
      .dropped (dropped0)
   );

   pulse_gen #(
      .HIGH_CYCLES  (4),
      .GAP_CYCLES   (0),
      .ACTIVE_LEVEL (1'b0)
   ) dut1 (
      .clk     (clk),
      .rst     (rst),
      .trig    (trig1),
      .out     (out1),
      .busy    (busy1),
      .dropped (dropped1)
   );

   // Drive trig for the current cycle, advance one clock, settle past the edge
   task automatic tick(input logic t0, input logic t1);
      trig0 = t0;
      trig1 = t1;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int cyc, input logic obs, input logic exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp_v);
      end
   endtask

   initial begin
      rst   = 1'b1;
      trig0 = 1'b0;
      trig1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset state
      chk("rst.out0",     0, out0,     1'b0);
      chk("rst.busy0",    0, busy0,    1'b0);
      chk("rst.dropped0", 0, dropped0, 1'b0);
      chk("rst.out1",     0, out1,     1'b1);
      chk("rst.busy1",    0, busy1,    1'b0);
      rst = 1'b0;

      // A: single trig in the very first cycle after reset release
      for (int c = 0; c < 9; c++) begin
         tick(c == 0, 1'b0);
         k = c + 1;
         chk("A.out",     k, out0,     (k >= 1 && k <= 4));
         chk("A.busy",    k, busy0,    (k >= 1 && k <= 6));
         chk("A.dropped", k, dropped0, 1'b0);
         chk("A.out1",    k, out1,     1'b1);
      end

      // B: second trig in the final gap cycle starts the next pulse
      for (int c = 0; c < 14; c++) begin
         tick(c == 0 || c == 6, 1'b0);
         k = c + 1;
         chk("B.out",     k, out0,     (k >= 1 && k <= 4) || (k >= 7 && k <= 10));
         chk("B.busy",    k, busy0,    (k >= 1 && k <= 12));
         chk("B.dropped", k, dropped0, 1'b0);
      end

`ifdef PULSE_GEN_QUEUE_EN
      // C: five trigs in a row; three queue, the fifth is discarded
      for (int c = 0; c < 27; c++) begin
         tick(c <= 4, 1'b0);
         k = c + 1;
         chk("C.out",     k, out0,     (k >= 1 && k <= 22 && ((k - 1) % 6) < 4));
         chk("C.busy",    k, busy0,    (k >= 1 && k <= 24));
         chk("C.dropped", k, dropped0, (k == 5));
      end

      // D: trig in a non-final gap cycle is queued
      for (int c = 0; c < 14; c++) begin
         tick(c == 0 || c == 5, 1'b0);
         k = c + 1;
         chk("D.out",     k, out0,     (k >= 1 && k <= 4) || (k >= 7 && k <= 10));
         chk("D.busy",    k, busy0,    (k >= 1 && k <= 12));
         chk("D.dropped", k, dropped0, 1'b0);
      end
`else
      // C: trig during the active phase is discarded
      for (int c = 0; c < 9; c++) begin
         tick(c == 0 || c == 2, 1'b0);
         k = c + 1;
         chk("C.out",     k, out0,     (k >= 1 && k <= 4));
         chk("C.busy",    k, busy0,    (k >= 1 && k <= 6));
         chk("C.dropped", k, dropped0, (k == 3));
      end

      // D: trig in a non-final gap cycle is discarded
      for (int c = 0; c < 9; c++) begin
         tick(c == 0 || c == 5, 1'b0);
         k = c + 1;
         chk("D.out",     k, out0,     (k >= 1 && k <= 4));
         chk("D.busy",    k, busy0,    (k >= 1 && k <= 6));
         chk("D.dropped", k, dropped0, (k == 6));
      end
`endif

      // E: asynchronous reset in the middle of a pulse with requests outstanding
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      chk("E.out_pre",  3, out0,  1'b1);
      chk("E.busy_pre", 3, busy0, 1'b1);
`ifdef PULSE_GEN_QUEUE_EN
      chk("E.dropped_pre", 3, dropped0, 1'b0);
`else
      chk("E.dropped_pre", 3, dropped0, 1'b1);
`endif
      trig0 = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      chk("E.out_async",     3, out0,     1'b0);
      chk("E.busy_async",    3, busy0,    1'b0);
      chk("E.dropped_async", 3, dropped0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick(1'b0, 1'b0);
         k = c + 1;
         chk("E.out",     k, out0,     1'b0);
         chk("E.busy",    k, busy0,    1'b0);
         chk("E.dropped", k, dropped0, 1'b0);
      end

      // F: active-low output, zero gap, back-to-back pulses merge
      for (int c = 0; c < 11; c++) begin
         tick(1'b0, c == 0 || c == 4);
         k = c + 1;
         chk("F.out1",     k, out1,     !(k >= 1 && k <= 8));
         chk("F.busy1",    k, busy1,    (k >= 1 && k <= 8));
         chk("F.dropped1", k, dropped1, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
